evp_addr_seq: RTL and testbench

Sequencer for the EVP (evaluate-polynomial) instruction, directly upstream of the N-address mux: it drives `rd_addr_N_EVP`, which the mux forwards to the degree (N) memory while `instr` is EVP. It reads polynomial `poly_id`'s degree from N memory, walks that polynomial's coefficient memory from highest to lowest index, and evaluates the polynomial at `x` by Horner's method. The result goes to the output stage with a one-cycle `done` pulse.

---
 rtl/evp_addr_seq.sv | 133 +++++++++++++
 tb/tb_evp_addr_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/evp_addr_seq.sv
// evp_addr_seq: EVP instruction sequencer. Reads a polynomial's degree from
// N memory, walks its coefficients from highest to lowest index and evaluates
// the polynomial at x by Horner's method (unsigned, modulo 2^word_size).
module evp_addr_seq #(
  parameter int n_size    = 8,
  parameter int p_size    = 16,
  parameter int word_size = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [7:0]                             instr,
  input  logic [$clog2(n_size)-1:0]              poly_id,
  input  logic [word_size-1:0]                   x,
  output logic [$clog2(n_size)-1:0]              rd_addr_N_EVP,
  input  logic [$clog2(p_size)-1:0]              rd_data_N,
  output logic [$clog2(n_size)+$clog2(p_size)-1:0] rd_addr_C,
  input  logic [word_size-1:0]                   rd_data_C,
  output logic [word_size-1:0]                   result,
  output logic                                   done,
  output logic                                   busy
);

  localparam int NW = $clog2(n_size);
  localparam int PW = $clog2(p_size);

  localparam logic [7:0]    OP_EVP  = 8'h01;
  localparam logic [7:0]    OP_RST  = 8'h03;
  localparam logic [PW-1:0] IDX_ONE = PW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_N,
    S_CAP_N,
    S_RD_C,
    S_ACC,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [NW-1:0]          r_pid;
  logic [word_size-1:0]   r_x;
  logic [word_size-1:0]   r_acc;
  logic [PW-1:0]          r_idx;
  logic [NW-1:0]          r_addr_n;
  logic [NW+PW-1:0]       r_addr_c;
  logic [word_size-1:0]   r_result;
  logic                   r_done;
  logic                   r_busy;

  logic [word_size-1:0]   w_mac;
  logic [PW-1:0]          w_idx_dec;

  // Horner step: product and sum both wrap at word_size bits
  always_comb begin
    w_mac     = r_acc * r_x + rd_data_C;
    w_idx_dec = r_idx - IDX_ONE;
  end

  // Sequencer FSM with registered address, result and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pid    <= '0;
      r_x      <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_addr_n <= '0;
      r_addr_c <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Abort wins over every in-flight step so no partial result is committed
      if (r_state != S_IDLE && instr == OP_RST) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && instr == OP_EVP) begin
              r_pid    <= poly_id;
              r_x      <= x;
              r_addr_n <= poly_id;
              r_busy   <= 1'b1;
              r_state  <= S_RD_N;
            end
          end
          S_RD_N: begin
            r_state <= S_CAP_N;
          end
          S_CAP_N: begin
            r_idx    <= rd_data_N;
            r_addr_c <= {r_pid, rd_data_N};
            r_acc    <= '0;
            r_state  <= S_RD_C;
          end
          S_RD_C: begin
            r_state <= S_ACC;
          end
          S_ACC: begin
            r_acc <= w_mac;
            if (r_idx == '0) begin
              r_result <= w_mac;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_idx    <= w_idx_dec;
              r_addr_c <= {r_pid, w_idx_dec};
              r_state  <= S_RD_C;
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rd_addr_N_EVP = r_addr_n;
  assign rd_addr_C     = r_addr_c;
  assign result        = r_result;
  assign done          = r_done;
  assign busy          = r_busy;

endmodule

// File: tb/tb_evp_addr_seq.sv
// Directed bench for evp_addr_seq with synchronous-read N/C memory models.
module tb_evp_addr_seq;

  localparam logic [7:0] OP_STP = 8'h00;
  localparam logic [7:0] OP_EVP = 8'h01;
  localparam logic [7:0] OP_EVB = 8'h02;
  localparam logic [7:0] OP_RST = 8'h03;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  instr;
  logic [2:0]  poly_id;
  logic [15:0] x;
  logic [2:0]  rd_addr_N_EVP;
  logic [3:0]  rd_data_N;
  logic [6:0]  rd_addr_C;
  logic [15:0] rd_data_C;
  logic [15:0] result;
  logic        done;
  logic        busy;

  logic [3:0]  nmem [8];
  logic [15:0] cmem [128];

  int tests = 0;
  int fails = 0;

  evp_addr_seq #(.n_size(8), .p_size(16), .word_size(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .instr         (instr),
    .poly_id       (poly_id),
    .x             (x),
    .rd_addr_N_EVP (rd_addr_N_EVP),
    .rd_data_N     (rd_data_N),
    .rd_addr_C     (rd_addr_C),
    .rd_data_C     (rd_data_C),
    .result        (result),
    .done          (done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read memories
  always @(posedge clk) begin
    rd_data_N <= nmem[rd_addr_N_EVP];
    rd_data_C <= cmem[rd_addr_C];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full evaluation; caller is just after an edge (cycle 0). Optional second
  // EVP start pulse at cycle restart_cyc must be ignored.
  task automatic run_evp(input logic [2:0] pid, input logic [15:0] xv, input int d,
                         input logic [15:0] exp_r, input int restart_cyc);
    logic [3:0] eidx;
    poly_id = pid;
    x       = xv;
    instr   = OP_EVP;
    start   = 1'b1;
    for (int cyc = 1; cyc <= 2 * d + 5; cyc++) begin
      tick();
      start = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        poly_id = 3'd5;
        x       = 16'd100;
      end
      chk("busy", 32'(busy), 32'd1);
      chk("done_timing", 32'(done), 32'(cyc == 2 * d + 5));
      if (cyc == 1) chk("rd_addr_N", 32'(rd_addr_N_EVP), 32'(pid));
      if (cyc >= 3 && cyc <= 2 * d + 4) begin
        eidx = 4'(d - (cyc - 3) / 2);
        chk("rd_addr_C", 32'(rd_addr_C), 32'({pid, eidx}));
      end
      if (cyc == 2 * d + 5) chk("result", 32'(result), 32'(exp_r));
    end
    start = 1'b0;
    tick();
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_after", 32'(done), 32'd0);
    chk("result_hold", 32'(result), 32'(exp_r));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) nmem[i] = 4'd0;
    for (int i = 0; i < 128; i++) cmem[i] = 16'd0;
    nmem[2] = 4'd2; cmem[{3'd2, 4'd2}] = 16'd3; cmem[{3'd2, 4'd1}] = 16'd2; cmem[{3'd2, 4'd0}] = 16'd1;
    nmem[5] = 4'd0; cmem[{3'd5, 4'd0}] = 16'd7;
    nmem[3] = 4'd1; cmem[{3'd3, 4'd1}] = 16'hFFFF; cmem[{3'd3, 4'd0}] = 16'd2;
    nmem[6] = 4'd3;
    for (int i = 0; i < 4; i++) cmem[{3'd6, 4'(i)}] = 16'd1;

    start = 1'b0; instr = OP_STP; poly_id = '0; x = '0;
    rst = 1'b0;
    #3;
    chk("rst_addrN", 32'(rd_addr_N_EVP), 32'd0);
    chk("rst_addrC", 32'(rd_addr_C), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // 3*4 + 2*2 + 1 = 17
    run_evp(3'd2, 16'd2, 2, 16'd17, -1);

    // non-EVP opcode with start is ignored
    instr = OP_EVB; start = 1'b1; poly_id = 3'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("evb_busy", 32'(busy), 32'd0);
      chk("evb_done", 32'(done), 32'd0);
    end
    start = 1'b0;
    chk("evb_result", 32'(result), 32'd17);
    tick();

    run_evp(3'd5, 16'd100, 0, 16'd7, -1);
    // FFFF*2+2 wraps to 0
    run_evp(3'd3, 16'd2, 1, 16'h0000, -1);
    // second start while busy is ignored
    run_evp(3'd2, 16'd2, 2, 16'd17, 3);

    // abort in first ACC of a degree-3 evaluation
    poly_id = 3'd6; x = 16'd3; instr = OP_EVP; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("abort_pre_busy", 32'(busy), 32'd1);
    instr = OP_RST;
    tick();
    instr = OP_STP;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addrC", 32'(rd_addr_C), 32'({3'd6, 4'd3}));
    for (int i = 0; i < 10; i++) begin
      chk("abort_done", 32'(done), 32'd0);
      tick();
    end
    chk("abort_result", 32'(result), 32'd17);

    // asynchronous reset mid-evaluation
    poly_id = 3'd2; x = 16'd2; instr = OP_EVP; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("mrst_addrN", 32'(rd_addr_N_EVP), 32'd0);
    chk("mrst_addrC", 32'(rd_addr_C), 32'd0);
    chk("mrst_result", 32'(result), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    instr = OP_STP;
    tick();
    run_evp(3'd2, 16'd2, 2, 16'd17, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
